op2_sel_pipe: RTL and testbench
===============================

Name: op2_sel_pipe

Overview:
- Parametrised, registered successor to the operand-2 selector in the IL execute stage.
- Selects operand 2 from N single-bit sources, M word sources or an immediate.
- Optionally extracts one bit from a word source and optionally negates the result (for ANDN/ORN/XORN-style instructions).
- Delivers the result through a one-deep valid/ready output register, so the ALU stage can stall. Illegal selects produce zero plus an error flag, never high-Z.

Parameters:
- WIDTH, 8: operand width in bits (>=2).
- NUM_BIT, 3: number of single-bit sources (>=1).
- NUM_WORD, 1: number of WIDTH-bit word sources (>=1).
- SEL_W, 3: select width; must satisfy 2^SEL_W >= NUM_BIT+NUM_WORD+1.
- IDX_W, 3: bit-index width; must satisfy 2^IDX_W >= WIDTH.
- ERR_CNT_W, 8: width of the saturating illegal-select counter.

Ports:
- clk, input, 1: the single clock; every flop is on the rising edge.
- reset, input, 1: synchronous, active-low reset; sampled on the rising clk edge.
- in_valid, input, 1: request is present.
- in_ready, output, 1: the block accepts a request this cycle.
- sel, input, SEL_W: source select.
- bit_src, input, NUM_BIT: bit sources; bit k is source k.
- word_src, input, NUM_WORD*WIDTH: word sources; word j is bits [j*WIDTH +: WIDTH].
- imm, input, WIDTH: immediate operand.
- extract, input, 1: for a word source, use only bit bit_idx.
- bit_idx, input, IDX_W: index used by extract.
- neg, input, 1: negate the result.
- out_valid, output, 1: op2_out holds a result.
- out_ready, input, 1: the consumer takes the result.
- op2_out, output, WIDTH: registered operand 2.
- sel_err, output, 1: the current result came from an illegal select or illegal index.
- err_cnt, output, ERR_CNT_W: saturating count of accepted illegal requests.

Behaviour:
- Reset (reset==0 at an edge): out_valid=0, op2_out=0, sel_err=0, err_cnt=0. Reset overrides any concurrent transfer; a request offered in the reset cycle is dropped.
- in_ready = !out_valid || out_ready. It is combinational and independent of in_valid.
- Accept when in_valid && in_ready. Latency is 1 cycle: the result appears on op2_out with out_valid=1 on the next edge.
- When out_valid && out_ready && !accept: out_valid goes to 0 and op2_out holds its value.
- While out_valid && !out_ready: op2_out, sel_err and out_valid stay frozen, and inputs are ignored.
- A simultaneous accept and drain (full output with out_ready=1, plus in_valid) passes the new result through the same cycle, giving back-to-back throughput of 1 per cycle.
- Select decode, evaluated at accept:
  - sel < NUM_BIT: raw = {0…, bit_src[sel]}. This is the bit class.
  - NUM_BIT <= sel < NUM_BIT+NUM_WORD: raw = word_src word (sel-NUM_BIT). This is the word class.
  - sel == NUM_BIT+NUM_WORD: raw = imm. This is the word class.
  - sel above that: illegal; raw = 0, and neg and extract are ignored.
- Extract:
  - Applies only to the word class. Result is {0…, word[bit_idx]} and is then treated as bit class.
  - If bit_idx >= WIDTH, the result is 0 and the request is flagged as an error.
  - extract is ignored for the bit class.
- Negate:
  - Bit class: only bit 0 is inverted; the upper bits stay 0.
  - Word class: bitwise invert over all WIDTH bits.
- sel_err is registered with op2_out for each accepted request. It is 1 for an illegal select or an illegal extract index.
- err_cnt increments by 1 per accepted erroneous request and saturates at all-ones; it never wraps. It is cleared only by reset.
- No X or Z is ever driven on any output.

Decomposition:
- Shared package/defines file holds:
  - the select-class encodings (BIT, WORD, IMM, ILLEGAL) as localparam/`define;
  - the sel base offsets (NUM_BIT, NUM_BIT+NUM_WORD);
  - the default WIDTH.
- One natural sub-module, op2_sel_decode: purely combinational. It takes sel, extract, bit_idx and neg and produces raw_result and err.
- The top level holds the handshake register and the error counter.

Test Plan:
1. Reset and basic select:
   - Stimulus: reset=0 for 2 cycles, then release. Defaults, bit_src=3'b010, sel=1, in_valid=1, out_ready=1.
   - Required: outputs all 0 during reset; one cycle after accept, op2_out=8'h01, out_valid=1, sel_err=0.
2. Word select with negate:
   - Stimulus: word_src=8'hA5, sel=3, neg=1; then imm=8'h3C, sel=4, neg=0.
   - Required: op2_out=8'h5A, then op2_out=8'h3C on consecutive cycles.
3. Extract, legal and illegal:
   - Stimulus: word_src=8'h80, sel=3, extract=1, bit_idx=7, neg=1.
   - Required: op2_out=8'h00 (bit 1 negated in bit 0 only).
   - Follow-up: WIDTH=6 build with bit_idx=7.
   - Required: op2_out=0, sel_err=1, err_cnt=1.
4. Illegal selects and counter saturation:
   - Stimulus: sel=5, 6, 7 repeated 300 times with ERR_CNT_W=8.
   - Required: op2_out=0, sel_err=1 each time; err_cnt stops at 8'hFF.
5. Backpressure:
   - Stimulus: out_ready=0 for 3 cycles after the first result while in_valid stays 1.
   - Required: in_ready=0 and op2_out frozen throughout.
   - Then: raise out_ready. Required: the next request is accepted in that same cycle (no bubble).
6. Reset mid-operation:
   - Stimulus: reset=0 while out_valid=1 and out_ready=0.
   - Required: out_valid=0, op2_out=0, err_cnt=0 at the next edge; the pending request is lost.

Source files
------------

// File: rtl/op2_sel_pipe_pkg.sv
// Shared definitions for the registered operand-2 selector.
// Select classes, default sizes and sel base offsets.
package op2_sel_pipe_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_NUM_BIT  = 3;
  localparam int DEF_NUM_WORD = 1;

  typedef enum logic [1:0] {
    CLS_BIT     = 2'd0,
    CLS_WORD    = 2'd1,
    CLS_IMM     = 2'd2,
    CLS_ILLEGAL = 2'd3
  } sel_cls_e;

  function automatic int unsigned word_base(
    input int unsigned nb
  );
    return nb;
  endfunction

  function automatic int unsigned imm_base(
    input int unsigned nb,
    input int unsigned nw
  );
    return nb + nw;
  endfunction

  function automatic sel_cls_e sel_class(
    input int unsigned sel,
    input int unsigned nb,
    input int unsigned nw
  );
    if (sel < word_base(nb))
      return CLS_BIT;
    if (sel < imm_base(nb, nw))
      return CLS_WORD;
    if (sel == imm_base(nb, nw))
      return CLS_IMM;
    return CLS_ILLEGAL;
  endfunction

endpackage

// File: rtl/op2_sel_decode.sv
// Combinational operand-2 source decode with
// optional bit extract and negate.
import op2_sel_pipe_pkg::*;

module op2_sel_decode #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_BIT  = DEF_NUM_BIT,
  parameter int NUM_WORD = DEF_NUM_WORD,
  parameter int SEL_W    = 3,
  parameter int IDX_W    = 3
) (
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_BIT-1:0]        bit_src,
  input  logic [NUM_WORD*WIDTH-1:0] word_src,
  input  logic [WIDTH-1:0]          imm,
  input  logic                      extract,
  input  logic [IDX_W-1:0]          bit_idx,
  input  logic                      neg,
  output logic [WIDTH-1:0]          raw_result,
  output logic                      err
);

  sel_cls_e         cls;
  logic             bit_v;
  logic [WIDTH-1:0] word_v;
  logic             ext_v;
  logic             idx_ok;

  always_comb begin
    cls    = sel_class(32'(sel), NUM_BIT, NUM_WORD);
    bit_v  = 1'b0;
    word_v = imm;
    ext_v  = 1'b0;
    for (int k = 0; k < NUM_BIT; k++)
      if (sel == SEL_W'(k))
        bit_v = bit_src[k];
    for (int j = 0; j < NUM_WORD; j++)
      if (sel == SEL_W'(NUM_BIT + j))
        word_v = word_src[j*WIDTH +: WIDTH];
    for (int i = 0; i < WIDTH; i++)
      if (bit_idx == IDX_W'(i))
        ext_v = word_v[i];
    idx_ok = 32'(bit_idx) < 32'(WIDTH);
  end

  // extracted bits join the bit class, so neg only flips bit 0
  always_comb begin
    raw_result = '0;
    err        = 1'b0;
    unique case (1'b1)
      cls == CLS_BIT: begin
        raw_result[0] = bit_v ^ neg;
      end
      (cls == CLS_WORD) || (cls == CLS_IMM): begin
        if (extract) begin
          if (idx_ok)
            raw_result[0] = ext_v ^ neg;
          else
            err = 1'b1;
        end else begin
          raw_result = neg ? ~word_v : word_v;
        end
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/op2_sel_pipe.sv
// Operand-2 selector with a one-deep valid/ready
// output register and a saturating error counter.
import op2_sel_pipe_pkg::*;

module op2_sel_pipe #(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_BIT   = DEF_NUM_BIT,
  parameter int NUM_WORD  = DEF_NUM_WORD,
  parameter int SEL_W     = 3,
  parameter int IDX_W     = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_BIT-1:0]        bit_src,
  input  logic [NUM_WORD*WIDTH-1:0] word_src,
  input  logic [WIDTH-1:0]          imm,
  input  logic                      extract,
  input  logic [IDX_W-1:0]          bit_idx,
  input  logic                      neg,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          op2_out,
  output logic                      sel_err,
  output logic [ERR_CNT_W-1:0]      err_cnt
);

  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     op2_q, op2_d;
  logic                 sel_err_q, sel_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0]     raw;
  logic                 dec_err;
  logic                 accept;

  op2_sel_decode #(
    .WIDTH    (WIDTH),
    .NUM_BIT  (NUM_BIT),
    .NUM_WORD (NUM_WORD),
    .SEL_W    (SEL_W),
    .IDX_W    (IDX_W)
  ) u_decode (
    .sel        (sel),
    .bit_src    (bit_src),
    .word_src   (word_src),
    .imm        (imm),
    .extract    (extract),
    .bit_idx    (bit_idx),
    .neg        (neg),
    .raw_result (raw),
    .err        (dec_err)
  );

  // draining and refilling in one cycle keeps full throughput
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    op2_d       = op2_q;
    sel_err_d   = sel_err_q;
    err_cnt_d   = err_cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      op2_d       = raw;
      sel_err_d   = dec_err;
      if (dec_err && (err_cnt_q != '1))
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      op2_q       <= '0;
      sel_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      op2_q       <= op2_d;
      sel_err_q   <= sel_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign op2_out   = op2_q;
  assign sel_err   = sel_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_op2_sel_pipe.sv
// Bench for op2_sel_pipe: directed scenarios plus random
// traffic against a behavioural reference model.
module tb_op2_sel_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] sel;
  logic [2:0] bit_src;
  logic [7:0] word_src;
  logic [7:0] imm;
  logic       extract;
  logic [2:0] bit_idx;
  logic       neg;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] op2_out;
  logic       sel_err;
  logic [7:0] err_cnt;

  logic [5:0] word6, imm6, op2_6;
  logic       in_ready6, out_valid6, sel_err6;
  logic [7:0] err_cnt6;

  int checks = 0;
  int errors = 0;

  // model state
  logic       m_valid;
  logic [7:0] m_out;
  logic       m_err;
  int         m_cnt;

  always #5 clk = ~clk;

  assign word6 = word_src[5:0];
  assign imm6  = imm[5:0];

  op2_sel_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .bit_src   (bit_src),
    .word_src  (word_src),
    .imm       (imm),
    .extract   (extract),
    .bit_idx   (bit_idx),
    .neg       (neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op2_out   (op2_out),
    .sel_err   (sel_err),
    .err_cnt   (err_cnt)
  );

  op2_sel_pipe #(.WIDTH(6)) dut6 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready6),
    .sel       (sel),
    .bit_src   (bit_src),
    .word_src  (word6),
    .imm       (imm6),
    .extract   (extract),
    .bit_idx   (bit_idx),
    .neg       (neg),
    .out_valid (out_valid6),
    .out_ready (out_ready),
    .op2_out   (op2_6),
    .sel_err   (sel_err6),
    .err_cnt   (err_cnt6)
  );

  // returns {err, value} for the 8-bit, 3-bit-source, 1-word build
  function automatic logic [8:0] ref_op2(
    input int s, input logic [2:0] b, input logic [7:0] w,
    input logic [7:0] im, input logic x, input int idx,
    input logic n
  );
    logic [7:0] v;
    logic       is_bit;
    if (s > 4) return 9'h100;
    if (s < 3) begin
      v      = {7'd0, b[s]};
      is_bit = 1'b1;
    end else begin
      v      = (s == 4) ? im : w;
      is_bit = 1'b0;
      if (x) begin
        if (idx >= 8) return 9'h100;
        v      = (v >> idx) & 8'h01;
        is_bit = 1'b1;
      end
    end
    if (n) v = is_bit ? (v ^ 8'h01) : ~v;
    return {1'b0, v};
  endfunction

  always @(posedge clk) begin
    logic [8:0] r;
    if (!reset) begin
      m_valid = 1'b0;
      m_out   = 8'h00;
      m_err   = 1'b0;
      m_cnt   = 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      r       = ref_op2(int'(sel), bit_src, word_src, imm,
                        extract, int'(bit_idx), neg);
      m_valid = 1'b1;
      m_out   = r[7:0];
      m_err   = r[8];
      if (r[8] && m_cnt < 255) m_cnt = m_cnt + 1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    sel = 3'd1; bit_src = 3'b010; word_src = 8'h00;
    imm = 8'h00; extract = 1'b0; bit_idx = 3'd0; neg = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({out_valid, op2_out, sel_err, err_cnt, in_ready}
          !== {1'b0, 8'h00, 1'b0, 8'h00, 1'b1}) begin
        errors++;
        $display("FAIL reset_state: v=%b op2=%h err=%b cnt=%h rdy=%b, want 0/00/0/00/1",
                 out_valid, op2_out, sel_err, err_cnt, in_ready);
      end
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({out_valid, op2_out, sel_err} !== {1'b1, 8'h01, 1'b0}) begin
      errors++;
      $display("FAIL basic_bit_sel: v=%b op2=%h err=%b, want 1/01/0",
               out_valid, op2_out, sel_err);
    end
  endtask

  task automatic test_word_neg();
    word_src = 8'hA5; sel = 3'd3; neg = 1'b1;
    tick();
    checks++;
    if ({out_valid, op2_out, sel_err} !== {1'b1, 8'h5A, 1'b0}) begin
      errors++;
      $display("FAIL word_neg: v=%b op2=%h err=%b, want 1/5a/0",
               out_valid, op2_out, sel_err);
    end
    imm = 8'h3C; sel = 3'd4; neg = 1'b0;
    tick();
    checks++;
    if ({out_valid, op2_out, sel_err} !== {1'b1, 8'h3C, 1'b0}) begin
      errors++;
      $display("FAIL imm_sel: v=%b op2=%h err=%b, want 1/3c/0",
               out_valid, op2_out, sel_err);
    end
  endtask

  task automatic test_extract();
    word_src = 8'h80; sel = 3'd3; extract = 1'b1;
    bit_idx = 3'd7; neg = 1'b1;
    tick();
    checks++;
    if ({out_valid, op2_out, sel_err, err_cnt}
        !== {1'b1, 8'h00, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL extract_neg: v=%b op2=%h err=%b cnt=%h, want 1/00/0/00",
               out_valid, op2_out, sel_err, err_cnt);
    end
    checks++;
    if ({out_valid6, op2_6, sel_err6, err_cnt6}
        !== {1'b1, 6'h00, 1'b1, 8'h01}) begin
      errors++;
      $display("FAIL extract_bad_idx_w6: v=%b op2=%h err=%b cnt=%h, want 1/00/1/01",
               out_valid6, op2_6, sel_err6, err_cnt6);
    end
    extract = 1'b0; neg = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      sel       = 3'($urandom_range(0, 5));
      bit_src   = 3'($urandom);
      word_src  = 8'($urandom);
      imm       = 8'($urandom);
      extract   = 1'($urandom);
      bit_idx   = 3'($urandom);
      neg       = 1'($urandom);
      #1;
      checks++;
      if (in_ready !== (!m_valid || out_ready)) begin
        errors++;
        $display("FAIL rand_in_ready[%0d]: got %b want %b",
                 i, in_ready, !m_valid || out_ready);
      end
      tick();
      checks++;
      if ({out_valid, op2_out, sel_err, err_cnt}
          !== {m_valid, m_out, m_err, 8'(m_cnt)}) begin
        errors++;
        $display("FAIL rand_out[%0d]: v=%b op2=%h err=%b cnt=%h, want %b/%h/%b/%h",
                 i, out_valid, op2_out, sel_err, err_cnt,
                 m_valid, m_out, m_err, 8'(m_cnt));
      end
    end
    extract = 1'b0; neg = 1'b0;
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; out_ready = 1'b1; sel = 3'd4; imm = 8'h11;
    tick();
    out_ready = 1'b0; imm = 8'h22;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({in_ready, out_valid, op2_out} !== {1'b0, 1'b1, 8'h11}) begin
        errors++;
        $display("FAIL stall[%0d]: rdy=%b v=%b op2=%h, want 0/1/11",
                 i, in_ready, out_valid, op2_out);
      end
    end
    out_ready = 1'b1; imm = 8'h33;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: got %b want 1", in_ready);
    end
    tick();
    checks++;
    if ({out_valid, op2_out} !== {1'b1, 8'h33}) begin
      errors++;
      $display("FAIL release_pass: v=%b op2=%h, want 1/33",
               out_valid, op2_out);
    end
  endtask

  task automatic test_illegal_sat();
    int base;
    int want;
    base = m_cnt;
    in_valid = 1'b1; out_ready = 1'b1; neg = 1'b1; extract = 1'b1;
    for (int i = 0; i < 300; i++) begin
      sel = 3'(5 + (i % 3));
      tick();
      want = (base + i + 1 > 255) ? 255 : base + i + 1;
      checks++;
      if ({out_valid, op2_out, sel_err, err_cnt}
          !== {1'b1, 8'h00, 1'b1, 8'(want)}) begin
        errors++;
        $display("FAIL illegal[%0d]: v=%b op2=%h err=%b cnt=%h, want 1/00/1/%h",
                 i, out_valid, op2_out, sel_err, err_cnt, 8'(want));
      end
    end
    neg = 1'b0; extract = 1'b0;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; out_ready = 1'b1; sel = 3'd4; imm = 8'h77;
    tick();
    out_ready = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if ({out_valid, op2_out, sel_err, err_cnt}
        !== {1'b0, 8'h00, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_mid: v=%b op2=%h err=%b cnt=%h, want 0/00/0/00",
               out_valid, op2_out, sel_err, err_cnt);
    end
    reset = 1'b1; in_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, op2_out} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_drop: v=%b op2=%h, want 0/00",
               out_valid, op2_out);
    end
  endtask

  initial begin
    test_reset();
    test_word_neg();
    test_extract();
    test_random();
    test_backpressure();
    test_illegal_sat();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
